mult_seq_ctrl: RTL and testbench



---
 rtl/mult_pkg.sv | 15 +
 rtl/booth_step.sv | 33 +++
 rtl/mult_seq_ctrl.sv | 118 +++++++++++
 tb/tb_mult_seq_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    localparam int MULT_WIDTH_DEF = 8;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of {A,Q,q_1}.
module booth_step
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEF
) (
    input  logic signed [WIDTH:0]   acc_i,
    input  logic        [WIDTH-1:0] q_i,
    input  logic                    q1_i,
    input  logic signed [WIDTH:0]   m_i,
    output logic signed [WIDTH:0]   acc_o,
    output logic        [WIDTH-1:0] q_o,
    output logic                    q1_o
);

    logic signed [WIDTH:0] sum;

    always_comb begin
        sum = acc_i;
        case ({q_i[0], q1_i})
            BOOTH_ADD: sum = acc_i + m_i;
            BOOTH_SUB: sum = acc_i - m_i;
            default:   sum = acc_i;
        endcase
    end

    // The MSB of A is replicated so the shift stays arithmetic.
    assign acc_o = {sum[WIDTH], sum[WIDTH:1]};
    assign q_o   = {sum[0], q_i[WIDTH-1:1]};
    assign q1_o  = q_i[0];

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential Booth multiplier controller: accept, WIDTH add/shift steps, hold.
// Optional macro MULT_SEQ_ZERO_SKIP_EN sends zero operands straight to DONE.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t                   state_q, state_d;
    logic signed [WIDTH:0]    acc_q, acc_d;
    logic        [WIDTH-1:0]  q_q, q_d;
    logic                     q1_q, q1_d;
    logic signed [WIDTH:0]    m_q, m_d;
    logic        [CW-1:0]     cnt_q, cnt_d;
    logic        [2*WIDTH-1:0] res_q, res_d;

    logic signed [WIDTH:0]    acc_s;
    logic        [WIDTH-1:0]  q_s;
    logic                     q1_s;
    logic                     accept;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i (acc_q),
        .q_i   (q_q),
        .q1_i  (q1_q),
        .m_i   (m_q),
        .acc_o (acc_s),
        .q_o   (q_s),
        .q1_o  (q1_s)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign result    = res_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q1_d    = q1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    m_d     = {a[WIDTH-1], a};
                    acc_d   = '0;
                    q_d     = b;
                    q1_d    = 1'b0;
                    cnt_d   = CW'(WIDTH);
                    state_d = ST_CALC;
`ifdef MULT_SEQ_ZERO_SKIP_EN
                    if ((a == '0) || (b == '0)) begin
                        state_d = ST_DONE;
                        res_d   = '0;
                    end
`endif
                end
            end
            ST_CALC: begin
                acc_d = acc_s;
                q_d   = q_s;
                q1_d  = q1_s;
                cnt_d = cnt_q - CW'(1);
                // Product of two WIDTH-bit signed values fits 2*WIDTH bits exactly.
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                    res_d   = {acc_s[WIDTH-1:0], q_s};
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed self-checking bench for mult_seq_ctrl at WIDTH=8.
module tb_mult_seq_ctrl;

    localparam int W = 8;
`ifdef MULT_SEQ_ZERO_SKIP_EN
    localparam int ZLAT = 0;
`else
    localparam int ZLAT = 8;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b1;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           in_ready;
    logic           out_valid;
    logic           busy;
    logic [2*W-1:0] result;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    mult_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_mult(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [2*W-1:0] exp, input int explat);
        int lat;
        out_ready = 1'b1;
        accept_op(tag, av, bv);
        wait_out(lat);
        chk({tag, "_lat"}, lat, explat);
        chk({tag, "_res"}, result, exp);
        @(posedge clk);
        #1;
        chk({tag, "_drain"}, out_valid, 1'b0);
        chk({tag, "_idle"}, in_ready, 1'b1);
    endtask

    logic [W-1:0]   pa [3];
    logic [W-1:0]   pb [3];
    logic [2*W-1:0] pe [3];
    int             acc_cyc [3];

    initial begin
        int lat;
        int k;
        pa = '{8'd5, 8'hF9, 8'h9C};
        pb = '{8'd6, 8'd4, 8'hFD};
        pe = '{16'h001E, 16'hFFE4, 16'h012C};

        // Reset state
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_result", result, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);

        // 3 * -5 with timing details
        accept_op("t1", 8'd3, 8'hFB);
        chk("t1_calc_in_ready", in_ready, 1'b0);
        chk("t1_calc_busy", busy, 1'b1);
        wait_out(lat);
        chk("t1_lat", lat, 8);
        chk("t1_res", result, 16'hFFF1);
        chk("t1_done_busy", busy, 1'b1);
        @(posedge clk);
        #1;
        chk("t1_one_clock", out_valid, 1'b0);
        chk("t1_res_held", result, 16'hFFF1);

        // Corner products
        do_mult("c1", 8'h80, 8'h80, 16'h4000, 8);
        do_mult("c2", 8'h7F, 8'h80, 16'hC080, 8);
        do_mult("c3", 8'hFF, 8'hFF, 16'h0001, 8);

        // Backpressure
        out_ready = 1'b0;
        accept_op("bp", 8'd12, 8'd10);
        wait_out(lat);
        chk("bp_lat", lat, 8);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_res", result, 16'h0078);
            chk("bp_hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_drain", out_valid, 1'b0);
        chk("bp_res_after", result, 16'h0078);

        // Reset mid-CALC
        accept_op("rs", 8'd7, 8'd9);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_out_valid", out_valid, 1'b0);
        chk("rs_busy", busy, 1'b0);
        chk("rs_result", result, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rs_in_ready", in_ready, 1'b1);
        do_mult("rs2", 8'd2, 8'd3, 16'h0006, 8);

        // Zero operand
        do_mult("zero", 8'd0, 8'hB3, 16'h0000, ZLAT);

        // Back-to-back with in_valid held high
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = pa[i];
            b = pb[i];
            in_valid = 1'b1;
            k = 0;
            @(negedge clk);
            while (in_ready !== 1'b1 && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("b2b_ready", in_ready, 1'b1);
            @(posedge clk);
            #1;
            acc_cyc[i] = cyc;
            if (i == 2) in_valid = 1'b0;
            chk("b2b_calc_in_ready", in_ready, 1'b0);
            wait_out(lat);
            chk("b2b_lat", lat, 8);
            chk("b2b_res", result, pe[i]);
            if (i > 0) chk("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 10);
        end
        @(posedge clk);
        #1;
        chk("b2b_final_drain", out_valid, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_no_extra", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
